// File: rtl/mem_req_arbiter_2p_if.sv
// Bundle of the two requester ports and the memory-controller command/data bus.
// The arbiter connects through the slave modport; its environment uses master.
interface mem_req_arbiter_2p_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
);
   logic              p0_req;
   logic              p1_req;
   logic              p0_we;
   logic              p1_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic [DATA_W-1:0] p1_wdata;
   logic              p0_gnt;
   logic              p1_gnt;
   logic              p0_rvalid;
   logic              p1_rvalid;
   logic [DATA_W-1:0] p0_rdata;
   logic [DATA_W-1:0] p1_rdata;
   logic              mem_we;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   modport slave (
      input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
      input  mem_dout,
      output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
      output mem_we, mem_re, mem_addr, mem_din
   );

   modport master (
      output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
      output mem_dout,
      input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
      input  mem_we, mem_re, mem_addr, mem_din
   );
endinterface

// File: rtl/mem_req_arbiter_2p.sv
// Two-port round-robin arbiter in front of the 8x8 memory controller: issues one
// command at a time and steers the one-cycle-late read data back to its owner.
module mem_req_arbiter_2p #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input logic                 clk,
   input logic                 reset,
   mem_req_arbiter_2p_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

   state_t            state;
   logic              last;
   logic              owner;
   logic              cmd_we;

   logic              win;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   // NOTE: each signal driven here gets a value on every path, so no latch is inferred.
   always_comb begin
      win = bus.p1_req;
      if (bus.p0_req && bus.p1_req) win = ~last;
      win_we    = win ? bus.p1_we    : bus.p0_we;
      win_addr  = win ? bus.p1_addr  : bus.p0_addr;
      win_wdata = win ? bus.p1_wdata : bus.p0_wdata;
   end

   // NOTE: state is updated with non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         last          <= 1'b1;
         owner         <= 1'b0;
         cmd_we        <= 1'b0;
         bus.p0_gnt    <= 1'b0;
         bus.p1_gnt    <= 1'b0;
         bus.p0_rvalid <= 1'b0;
         bus.p1_rvalid <= 1'b0;
         bus.p0_rdata  <= '0;
         bus.p1_rdata  <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_re    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_din   <= '0;
      end else begin
         // Pulses default low; the state that owns them raises them for one cycle.
         bus.p0_gnt    <= 1'b0;
         bus.p1_gnt    <= 1'b0;
         bus.p0_rvalid <= 1'b0;
         bus.p1_rvalid <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_re    <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.p0_req || bus.p1_req) begin
                  bus.mem_addr <= win_addr;
                  bus.mem_din  <= win_wdata;
                  bus.mem_we   <= win_we;
                  bus.mem_re   <= ~win_we;
                  bus.p0_gnt   <= ~win;
                  bus.p1_gnt   <= win;
                  cmd_we       <= win_we;
                  owner        <= win;
                  last         <= win;
                  state        <= CMD;
               end
            end

            CMD: state <= cmd_we ? IDLE : RDWAIT;

            // The controller's registered read data is valid this cycle.
            RDWAIT: begin
               if (owner) begin
                  bus.p1_rdata  <= bus.mem_dout;
                  bus.p1_rvalid <= 1'b1;
               end else begin
                  bus.p0_rdata  <= bus.mem_dout;
                  bus.p0_rvalid <= 1'b1;
               end
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter_2p.sv
// Randomised and directed bench for mem_req_arbiter_2p with a behavioural memory
// controller and a transaction-level reference model (grant order, timing, data).
module tb_mem_req_arbiter_2p;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_req_arbiter_2p_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_req_arbiter_2p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Stand-in for the 8x8 controller: synchronous write, registered read.
   logic [DATA_W-1:0] ctl_mem [DEPTH];
   logic [DATA_W-1:0] ctl_dout;
   assign bus.mem_dout = ctl_dout;
   always @(posedge clk) begin
      if (bus.mem_we) ctl_mem[bus.mem_addr] <= bus.mem_din;
      if (bus.mem_re) ctl_dout <= ctl_mem[bus.mem_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state.
   logic [DATA_W-1:0] ref_mem [DEPTH];
   bit                written [DEPTH];
   logic              ref_last;
   logic [DATA_W-1:0] exp_rdata [2];
   int                next_idle;
   int                last_gnt_cyc;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic set_port(input int p, input logic req, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (p == 0) begin
         bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
      end else begin
         bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
      end
   endtask

   task automatic model_reset();
      ref_last     = 1'b1;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      next_idle    = 0;
   endtask

   // Asserts reset between clock edges, checks outputs clear at once, releases on negedge.
   task automatic apply_reset(input string tag);
      @(posedge clk);
      #2;
      set_port(0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0);
      reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata,
           bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_din} !== '0) begin
         n_fail++;
         $display("FAIL %s: outputs not cleared gnt=%b%b rvalid=%b%b rdata=%h/%h we=%b re=%b addr=%h din=%h",
                  tag, bus.p1_gnt, bus.p0_gnt, bus.p1_rvalid, bus.p0_rvalid, bus.p0_rdata,
                  bus.p1_rdata, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_din);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // Presents the requested ports (held until granted) and checks every grant and read
   // return against the model. Called on a negedge.
   task automatic do_transaction(input logic [1:0] want, input logic [1:0] we,
                                 input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                                 input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
      logic [1:0]        pending;
      int                start, exp_cyc, waited, w;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d, rexp, got;
      logic              rd;
      pending = want;
      set_port(0, want[0], we[0], a0, d0);
      set_port(1, want[1], we[1], a1, d1);
      start = cyc;
      while (pending != 2'b00) begin
         if (pending == 2'b11) w = ref_last ? 0 : 1;
         else                  w = pending[1] ? 1 : 0;
         exp_cyc = ((start > next_idle) ? start : next_idle) + 1;
         waited = 0;
         do begin
            @(negedge clk);
            waited++;
            if (!(bus.p0_gnt || bus.p1_gnt)) begin
               n_checks++;
               if (bus.mem_we || bus.mem_re) begin
                  n_fail++;
                  $display("FAIL stray_strobe: we=%b re=%b without gnt at cycle %0d, required 0/0",
                           bus.mem_we, bus.mem_re, cyc);
               end
            end
         end while (!(bus.p0_gnt || bus.p1_gnt) && waited < 12);

         if (!(bus.p0_gnt || bus.p1_gnt)) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: no gnt within 12 cycles, pending=%b", pending);
            set_port(0, 1'b0, 1'b0, '0, '0);
            set_port(1, 1'b0, 1'b0, '0, '0);
            return;
         end

         a  = (w == 1) ? a1 : a0;
         d  = (w == 1) ? d1 : d0;
         rd = !((w == 1) ? we[1] : we[0]);

         n_checks++;
         if ({bus.p1_gnt, bus.p0_gnt} !== ((w == 1) ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL grant_port: gnt(p1,p0)=%b, required port %0d", {bus.p1_gnt, bus.p0_gnt}, w);
         end
         n_checks++;
         if (cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL grant_cycle: gnt at cycle %0d, required %0d", cyc, exp_cyc);
         end
         n_checks++;
         if ({bus.mem_we, bus.mem_re} !== {~rd, rd}) begin
            n_fail++;
            $display("FAIL cmd_strobe: we/re=%b%b, required %b%b", bus.mem_we, bus.mem_re, ~rd, rd);
         end
         n_checks++;
         if (bus.mem_addr !== a) begin
            n_fail++;
            $display("FAIL cmd_addr: mem_addr=%h, required %h", bus.mem_addr, a);
         end
         if (!rd) begin
            n_checks++;
            if (bus.mem_din !== d) begin
               n_fail++;
               $display("FAIL cmd_din: mem_din=%h, required %h", bus.mem_din, d);
            end
         end

         ref_last     = (w == 1);
         pending[w]   = 1'b0;
         set_port(w, 1'b0, 1'b0, '0, '0);
         last_gnt_cyc = cyc;
         next_idle    = cyc + (rd ? 2 : 1);

         if (!rd) begin
            ref_mem[a] = d;
            written[a] = 1'b1;
         end else begin
            rexp = ref_mem[a];
            @(negedge clk);
            n_checks++;
            if (bus.p0_rvalid || bus.p1_rvalid || bus.mem_we || bus.mem_re) begin
               n_fail++;
               $display("FAIL rdwait_quiet: rvalid=%b%b we=%b re=%b, required all 0",
                        bus.p1_rvalid, bus.p0_rvalid, bus.mem_we, bus.mem_re);
            end
            @(negedge clk);
            n_checks++;
            if ({bus.p1_rvalid, bus.p0_rvalid} !== ((w == 1) ? 2'b10 : 2'b01)) begin
               n_fail++;
               $display("FAIL rvalid_port: rvalid(p1,p0)=%b, required port %0d",
                        {bus.p1_rvalid, bus.p0_rvalid}, w);
            end
            got = (w == 1) ? bus.p1_rdata : bus.p0_rdata;
            n_checks++;
            if (got !== rexp) begin
               n_fail++;
               $display("FAIL rdata: p%0d_rdata=%h, required %h (addr %h)", w, got, rexp, a);
            end
            got = (w == 1) ? bus.p0_rdata : bus.p1_rdata;
            n_checks++;
            if (got !== exp_rdata[1-w]) begin
               n_fail++;
               $display("FAIL rdata_isolation: p%0d_rdata=%h, required %h", 1 - w, got, exp_rdata[1-w]);
            end
            exp_rdata[w] = rexp;
         end
      end
   endtask

   task automatic test_reset();
      do_transaction(2'b01, 2'b11, 3'd6, 3'd0, 8'h7E, 8'h00);
      do_transaction(2'b01, 2'b00, 3'd6, 3'd0, 8'h00, 8'h00);
      apply_reset("reset_values");
   endtask

   task automatic test_p0_write_read();
      do_transaction(2'b01, 2'b11, 3'd3, 3'd0, 8'hA5, 8'h00);
      do_transaction(2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00);
   endtask

   task automatic test_fairness();
      do_transaction(2'b01, 2'b11, 3'd1, 3'd0, 8'h5A, 8'h00);
      do_transaction(2'b10, 2'b11, 3'd0, 3'd2, 8'h00, 8'hC3);
      apply_reset("reset_pre_fairness");
      repeat (4) do_transaction(2'b11, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00);
   endtask

   task automatic test_back_to_back();
      int prev;
      prev = 0;
      for (int i = 0; i < 5; i++) begin
         do_transaction(2'b10, 2'b11, 3'd0, ADDR_W'(i + 2), 8'h00, DATA_W'($urandom));
         if (i > 0) begin
            n_checks++;
            if (last_gnt_cyc - prev != 2) begin
               n_fail++;
               $display("FAIL write_spacing: %0d cycles between writes, required 2", last_gnt_cyc - prev);
            end
         end
         prev = last_gnt_cyc;
      end
   endtask

   task automatic test_reset_mid_read();
      int waited;
      do_transaction(2'b01, 2'b11, 3'd5, 3'd0, 8'h3C, 8'h00);
      do_transaction(2'b01, 2'b00, 3'd5, 3'd0, 8'h00, 8'h00);
      do_transaction(2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00);
      set_port(0, 1'b1, 1'b0, 3'd5, 8'h00);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!bus.p0_gnt && waited < 12);
      set_port(0, 1'b0, 1'b0, '0, '0);
      if (!bus.p0_gnt) begin
         n_checks++;
         n_fail++;
         $display("FAIL midread_grant_timeout: no p0_gnt within 12 cycles");
      end
      // Grant seen in CMD; the next edge enters RDWAIT, where reset lands.
      apply_reset("reset_mid_read");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.p0_rvalid || bus.p1_rvalid || bus.p0_rdata !== '0 || bus.p1_rdata !== '0) begin
            n_fail++;
            $display("FAIL dropped_read: rvalid=%b%b rdata=%h/%h, required 00 and 00/00",
                     bus.p1_rvalid, bus.p0_rvalid, bus.p0_rdata, bus.p1_rdata);
         end
      end
      do_transaction(2'b01, 2'b00, 3'd5, 3'd0, 8'h00, 8'h00);
   endtask

   task automatic test_data_isolation();
      do_transaction(2'b01, 2'b11, 3'd0, 3'd0, 8'h11, 8'h00);
      do_transaction(2'b10, 2'b11, 3'd0, 3'd7, 8'h00, 8'hEE);
      do_transaction(2'b01, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
      do_transaction(2'b10, 2'b00, 3'd0, 3'd7, 8'h00, 8'h00);
      n_checks++;
      if (bus.p0_rdata !== 8'h11) begin
         n_fail++;
         $display("FAIL isolation_hold: p0_rdata=%h, required 11", bus.p0_rdata);
      end
   endtask

   task automatic test_random();
      logic [1:0]        want, we;
      logic [ADDR_W-1:0] a0, a1;
      for (int i = 0; i < 40; i++) begin
         want = 2'($urandom_range(1, 3));
         we   = 2'($urandom);
         a0   = ADDR_W'($urandom);
         a1   = ADDR_W'($urandom);
         // Reads only target locations already written, so the controller holds known data.
         if (!written[a0]) we[0] = 1'b1;
         if (!written[a1]) we[1] = 1'b1;
         do_transaction(want, we, a0, a1, DATA_W'($urandom), DATA_W'($urandom));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i] = '0;
         written[i] = 1'b0;
      end
      model_reset();
      last_gnt_cyc = 0;
      set_port(0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      test_reset();
      test_p0_write_read();
      test_fairness();
      test_back_to_back();
      test_reset_mid_read();
      test_data_isolation();
      test_random();

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
